parity_rr_scheduler: RTL

- Shares one chunked XOR-reduction parity engine among N_REQ requesters under round-robin arbitration.
- Each request carries a DATA_W-bit word. The engine folds CHUNK_W bits per cycle.
- Returns a single parity bit tagged with the requester index over a valid/ready output handshake.
- Sits between multiple producers and the parity-check/generation stage of the combinational parity datapath.

---
 rtl/parity_rr_scheduler.sv | 109 ++++++++++
 1 files changed

// File: rtl/parity_rr_scheduler.sv
// Round-robin front end for a shared, chunk-serial XOR parity engine.
// One word is folded CHUNK_W bits per cycle; the result is tagged with the requester index.
module parity_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 4,
  parameter int ODD     = 0,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    out_valid,
  output logic                    out_parity,
  output logic [IDW-1:0]          out_id,
  input  logic                    out_ready
);

  localparam int K  = DATA_W / CHUNK_W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   shift;
  logic                acc;
  logic [CW-1:0]       cnt;
  logic [IDW-1:0]      last;

  logic                pick_found;
  logic [IDW-1:0]      pick_idx;
  int                  scan;
  logic                chunk_x;
  logic                accept;

  // Scan last+1, last+2, ... so the most recently granted index has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      scan = (int'(last) + off) % N_REQ;
      if (!pick_found && req[scan]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(scan);
      end
    end
  end

  assign chunk_x = ^shift[CHUNK_W-1:0];
  assign accept  = out_valid & out_ready;

  // busy and out_valid are registered from the state, so they trail it by one cycle;
  // this keeps busy low in the grant cycle and gives a T+K+2 result latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_id     <= '0;
      shift      <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      last       <= IDW'(N_REQ - 1);
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          if (pick_found) begin
            gnt[pick_idx] <= 1'b1;
            last          <= pick_idx;
            out_id        <= pick_idx;
            shift         <= data[int'(pick_idx)*DATA_W +: DATA_W];
            acc           <= 1'b0;
            cnt           <= '0;
            state         <= COMPUTE;
          end
        end
        COMPUTE: begin
          busy  <= 1'b1;
          acc   <= acc ^ chunk_x;
          shift <= shift >> CHUNK_W;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(K - 1)) state <= DONE;
        end
        DONE: begin
          if (accept) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            out_valid  <= 1'b1;
            out_parity <= acc ^ (ODD != 0);
            busy       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
